pdm_dac_driver: RTL and testbench
=================================

Name: pdm_dac_driver

Overview:
- Final audio stage, directly downstream of the 16x upsampler.
- Takes its held 16-bit signed output and re-samples it on an internal update strobe, once per upsampled period (142 cycles at ~100 MHz).
- Applies a click-free soft mute/unmute gain ramp.
- Drives a 1-bit second-order delta-sigma bitstream to the PWM/PDM audio pin at full clock rate.

Parameters:
- UPDATE_PERIOD, 142, clock cycles between input re-samples; must match the upsampler output rate.
- RAMP_DIV, 16, update strobes per gain step; full ramp = 256*RAMP_DIV strobes.
- INT_W, 24, integrator width in bits, signed.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  level; 1 = unmute (ramp up), 0 = mute (ramp down)
- sample_in  input  16  signed held sample from the upsampler
- pdm_out  output  1  registered delta-sigma bitstream
- update_strobe  output  1  registered one-cycle pulse on each input re-sample
- active  output  1  registered; high only in RUN
- idle  output  1  registered; high only in IDLE

Behaviour:
- Reset/clock: one clock, clk; reset is asynchronous, active-low, on rst_n. All flops clear immediately when rst_n is low.
- Reset values: pdm_out=0, update_strobe=0, active=0, idle=1, gain=0, state=IDLE, update counter=0, ramp counter=0, integrators=0, x_reg=0.
- Update counter:
  - Counts 0..UPDATE_PERIOD-1 and wraps.
  - update_strobe is high in the cycle after the counter equals UPDATE_PERIOD-1. First pulse is at cycle UPDATE_PERIOD after reset release.
  - Runs in every state.
- Scaling, on each strobe cycle:
  - x_reg <= (sample_in * gain) >>> 8.
  - sample_in is signed; gain is 9-bit unsigned, 0..256. Product is 25-bit signed; the shift is arithmetic.
  - gain=256 gives exact passthrough; gain=0 gives x_reg=0.
  - Between strobes, x_reg holds.
- Modulator, every cycle when state != IDLE:
  - fb = pdm_out ? +32767 : -32768, sign-extended to INT_W.
  - i1_n = sat(i1 + x_reg - fb).
  - i2_n = sat(i2 + i1_n - fb).
  - pdm_out <= (i2_n >= 0).
  - sat() clamps to [-2^(INT_W-2), 2^(INT_W-2)-1]. This prevents wrap for any input, including -32768 held indefinitely.
- IDLE output:
  - Integrators are forced to 0.
  - pdm_out toggles every cycle (50% duty = zero level), starting from 0 after reset.
- Gain state machine (steps occur only on update_strobe cycles; ramp counter counts strobes to RAMP_DIV-1, then steps gain and clears):
  - IDLE: gain=0. enable=1 -> RAMP_UP; integrators start from 0 the next cycle.
  - RAMP_UP: gain +1 per step. gain reaching 256 -> RUN. enable=0 -> RAMP_DOWN, keeping the current gain and clearing the ramp counter.
  - RUN: gain=256. enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain -1 per step. gain reaching 0 -> IDLE, integrators cleared. enable=1 -> RAMP_UP, keeping the current gain and clearing the ramp counter.
  - enable is sampled every cycle; state transitions on enable take effect the next cycle.
- Simultaneous events: a state change and a strobe in the same cycle are allowed. The scale on that strobe uses the pre-change gain.
- Latency:
  - sample_in is captured at the strobe edge.
  - Its first effect on pdm_out appears 2 cycles after the strobe cycle: x_reg, then the modulator register.
- Reset mid-operation: outputs return to reset values asynchronously. After release, the block restarts in IDLE regardless of enable, then follows the state machine.

Decomposition:
- Package dac_pkg:
  - typedef enum logic [1:0] dac_state_t {IDLE, RAMP_UP, RUN, RAMP_DOWN}
  - localparams FB_POS=32767, FB_NEG=-32768, GAIN_MAX=256.
- Sub-module sd_mod2_core:
  - Inputs: clk, rst_n, clear, x (16-bit signed).
  - Output: bit.
  - Contents: the two saturating integrators and the quantiser.
- Top level holds the counters, scaler and FSM.

Test Plan:
- Reset: hold rst_n=0 with enable=1 -> pdm_out=0, idle=1, active=0. After release, pdm_out reads 0,1,0,1..., and update_strobe first pulses at cycle 142.
- Ramp timing (RAMP_DIV=1): assert enable with sample_in=16384 -> active rises after exactly 256 strobes (36352 cycles, ±2). x_reg steps 64, 128, ... up to 16384.
- DC accuracy in RUN:
  - sample_in=0 -> ones density 50% ±0.5% over 8192 cycles.
  - sample_in=16384 -> 75% ±0.5%.
  - sample_in=-16384 -> 25% ±0.5%.
- Full scale: sample_in=32767, then -32768, each for 100k cycles -> integrators never exceed the saturation bounds, and density is >99.5% / <0.5% respectively.
- Mid-ramp reversal (RAMP_DIV=1): drop enable at gain=100 -> gain reaches 0 and idle=1 after 100 further strobes. Re-assert enable at gain=50 during that descent -> gain resumes rising from 50.
- Async reset: pulse rst_n low for 3 ns mid-RUN, between clock edges -> all outputs are at reset values before the next clk edge, and the state is IDLE afterwards.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the PDM DAC output stage.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } dac_state_t;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned GAIN_W   = 9;
  localparam int          FB_POS   = 32767;
  localparam int          FB_NEG   = -32768;
  localparam int unsigned GAIN_MAX = 256;

endpackage

// File: rtl/sd_mod2_core.sv
// Second-order delta-sigma modulator: two saturating integrators and a 1-bit quantiser.
module sd_mod2_core
  import dac_pkg::*;
#(
  parameter int unsigned INT_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       bit_out
);

  // Two guard bits so the unclamped sums can never wrap before saturation.
  localparam int unsigned SUM_W = INT_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (INT_W - 2)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2 ** (INT_W - 2)));

  logic signed [INT_W-1:0] i1;
  logic signed [INT_W-1:0] i2;
  logic signed [INT_W-1:0] i1_n;
  logic signed [INT_W-1:0] i2_n;
  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] sum1;
  logic signed [SUM_W-1:0] sum2;

  function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return INT_W'(SAT_HI);
    end else if (v < SAT_LO) begin
      return INT_W'(SAT_LO);
    end else begin
      return INT_W'(v);
    end
  endfunction

  // Loop arithmetic: feedback from the current output bit into both integrators.
  always_comb begin
    fb   = bit_out ? SUM_W'(FB_POS) : SUM_W'(FB_NEG);
    sum1 = SUM_W'(i1) + SUM_W'(x) - fb;
    i1_n = sat(sum1);
    sum2 = SUM_W'(i2) + SUM_W'(i1_n) - fb;
    i2_n = sat(sum2);
  end

  // Integrator and quantiser registers; while cleared emit a 50% zero-level pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1      <= '0;
      i2      <= '0;
      bit_out <= 1'b0;
    end else if (clear) begin
      i1      <= '0;
      i2      <= '0;
      bit_out <= ~bit_out;
    end else begin
      i1      <= i1_n;
      i2      <= i2_n;
      bit_out <= ~i2_n[INT_W-1];
    end
  end

endmodule

// File: rtl/pdm_dac_driver.sv
// Final audio stage: re-samples the upsampler output, applies a soft mute ramp,
// and drives a second-order delta-sigma bitstream.
module pdm_dac_driver
  import dac_pkg::*;
#(
  parameter int unsigned UPDATE_PERIOD = 142,
  parameter int unsigned RAMP_DIV      = 16,
  parameter int unsigned INT_W         = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       pdm_out,
  output logic                       update_strobe,
  output logic                       active,
  output logic                       idle
);

  localparam int unsigned CNT_W  = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int unsigned RC_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned PROD_W = SAMPLE_W + GAIN_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RAMP_DIV - 1);
  localparam logic [GAIN_W-1:0] GAIN_TOP = GAIN_W'(GAIN_MAX);

  dac_state_t                 state;
  dac_state_t                 state_n;
  logic [GAIN_W-1:0]          gain;
  logic [GAIN_W-1:0]          gain_n;
  logic [RC_W-1:0]            ramp_cnt;
  logic [RC_W-1:0]            ramp_cnt_n;
  logic [CNT_W-1:0]           upd_cnt;
  logic signed [SAMPLE_W-1:0] x_reg;
  logic signed [PROD_W-1:0]   prod_c;
  logic                       ramp_tick;

  // Free-running re-sample counter; strobe follows the terminal count by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt       <= '0;
      update_strobe <= 1'b0;
    end else begin
      upd_cnt       <= (upd_cnt == CNT_LAST) ? '0 : upd_cnt + 1'b1;
      update_strobe <= (upd_cnt == CNT_LAST);
    end
  end

  // Signed sample times unsigned gain; gain of 256 is unity after the shift.
  always_comb begin
    prod_c = PROD_W'(sample_in) * PROD_W'($signed({1'b0, gain}));
  end

  // Capture the scaled sample on each strobe, using the gain in force before any step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
    end else if (update_strobe) begin
      x_reg <= SAMPLE_W'(prod_c >>> 8);
    end
  end

  // Gain ramp state machine: enable reacts every cycle, gain steps only on strobes.
  always_comb begin
    state_n    = state;
    gain_n     = gain;
    ramp_cnt_n = ramp_cnt;
    ramp_tick  = update_strobe && (ramp_cnt == RC_LAST);
    case (state)
      IDLE: begin
        gain_n     = '0;
        ramp_cnt_n = '0;
        if (enable) state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_n    = RAMP_DOWN;
          ramp_cnt_n = '0;
        end else if (gain == GAIN_TOP) begin
          state_n = RUN;
        end else if (update_strobe) begin
          if (ramp_tick) begin
            ramp_cnt_n = '0;
            gain_n     = gain + 1'b1;
            if (gain_n == GAIN_TOP) state_n = RUN;
          end else begin
            ramp_cnt_n = ramp_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        gain_n     = GAIN_TOP;
        ramp_cnt_n = '0;
        if (!enable) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_n    = RAMP_UP;
          ramp_cnt_n = '0;
        end else if (gain == '0) begin
          state_n = IDLE;
        end else if (update_strobe) begin
          if (ramp_tick) begin
            ramp_cnt_n = '0;
            gain_n     = gain - 1'b1;
            if (gain_n == '0) state_n = IDLE;
          end else begin
            ramp_cnt_n = ramp_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        gain_n     = '0;
        ramp_cnt_n = '0;
      end
    endcase
  end

  // State, gain and status flags; flags follow the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gain     <= '0;
      ramp_cnt <= '0;
      active   <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state    <= state_n;
      gain     <= gain_n;
      ramp_cnt <= ramp_cnt_n;
      active   <= (state_n == RUN);
      idle     <= (state_n == IDLE);
    end
  end

  sd_mod2_core #(
    .INT_W(INT_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .x      (x_reg),
    .bit_out(pdm_out)
  );

endmodule

// File: tb/tb_pdm_dac_driver.sv
// Self-checking bench for pdm_dac_driver with a fast ramp (RAMP_DIV=1).
`timescale 1ns/100ps
module tb_pdm_dac_driver;

  localparam int unsigned PERIOD = 142;
  localparam int          NWIN   = 4096;
  localparam int          TOL    = 20;
  localparam int          SETTLE = 300;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] sample_in;
  logic               pdm_out;
  logic               update_strobe;
  logic               active;
  logic               idle;

  int n_checks;
  int n_pass;
  int g;
  int i1_max, i1_min, i2_max, i2_min;

  pdm_dac_driver #(
    .UPDATE_PERIOD(PERIOD),
    .RAMP_DIV     (1),
    .INT_W        (24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .pdm_out      (pdm_out),
    .update_strobe(update_strobe),
    .active       (active),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track integrator extremes for the saturation-bound check.
  always @(negedge clk) begin
    if (dut.u_core.i1 > i1_max) i1_max = dut.u_core.i1;
    if (dut.u_core.i1 < i1_min) i1_min = dut.u_core.i1;
    if (dut.u_core.i2 > i2_max) i2_max = dut.u_core.i2;
    if (dut.u_core.i2 < i2_min) i2_min = dut.u_core.i2;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s observed=%0d required=[%0d,%0d]", tag, obs, lo, hi);
  endtask

  // Floor division by 256 (arithmetic-shift semantics for negative products).
  function automatic int floor_div256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic wait_strobe();
    int k;
    k = 0;
    @(negedge clk);
    while (update_strobe !== 1'b1 && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    check("strobe_seen", update_strobe, 1);
  endtask

  // One gain step: model gain moves by dir, scaled sample uses the pre-step gain.
  task automatic gain_step(input int dir, input bit rnd);
    int gp;
    int s;
    wait_strobe();
    check("gain_before_step", dut.gain, g);
    gp = g;
    s  = sample_in;
    @(negedge clk);
    g = g + dir;
    if (g > 256) g = 256;
    if (g < 0) g = 0;
    check("x_reg_scaled", dut.x_reg, floor_div256(s * gp));
    check("gain_after_step", dut.gain, g);
    check("active_flag", active, (g == 256));
    check("idle_flag", idle, (g == 0));
    if (rnd) sample_in = 16'($urandom);
    repeat (40) @(negedge clk);
    check("x_reg_held", dut.x_reg, floor_div256(s * gp));
  endtask

  task automatic check_release();
    for (int k = 1; k <= int'(PERIOD); k++) begin
      @(negedge clk);
      check("strobe_phase", update_strobe, (k == int'(PERIOD)));
      if (k <= 8) begin
        check("idle_pdm_toggle", pdm_out, k % 2);
        check("idle_after_reset", idle, 1);
      end
    end
  endtask

  initial begin
    int lv[5];
    int ones;
    int expv;
    n_checks = 0;
    n_pass   = 0;
    g        = 0;
    i1_max = 0; i1_min = 0; i2_max = 0; i2_min = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    sample_in = '0;

    // Reset held with enable high.
    repeat (3) @(negedge clk);
    check("rst_pdm", pdm_out, 0);
    check("rst_idle", idle, 1);
    check("rst_active", active, 0);
    check("rst_strobe", update_strobe, 0);
    check("rst_gain", dut.gain, 0);
    check("rst_x_reg", dut.x_reg, 0);
    enable = 1'b0;
    rst_n  = 1'b1;
    check_release();

    // Short ramp up and full descent back to IDLE.
    @(negedge clk);
    sample_in = 16'sd16384;
    enable    = 1'b1;
    repeat (10) gain_step(1, 1'b0);
    enable = 1'b0;
    repeat (10) gain_step(-1, 1'b0);

    // Mid-ramp reversal: up to 100, down to 50, then up to full gain.
    enable = 1'b1;
    repeat (100) gain_step(1, 1'b1);
    enable = 1'b0;
    repeat (50) gain_step(-1, 1'b1);
    check("gain_at_reversal", dut.gain, 50);
    enable = 1'b1;
    repeat (206) gain_step(1, 1'b1);
    check("run_active", active, 1);

    // DC density in RUN, including both full-scale extremes.
    lv = '{0, 16384, -16384, 32767, -32768};
    for (int i = 0; i < 5; i++) begin
      sample_in = 16'(lv[i]);
      wait_strobe();
      repeat (SETTLE) @(negedge clk);
      ones = 0;
      repeat (NWIN) begin
        @(negedge clk);
        ones += int'(pdm_out);
      end
      expv = int'(real'(lv[i] + 32768) * real'(NWIN) / 65535.0);
      check_range("dc_density", ones, (expv - TOL < 0) ? 0 : expv - TOL,
                  (expv + TOL > NWIN) ? NWIN : expv + TOL);
    end
    check_range("i1_upper", i1_max, -4194304, 4194303);
    check_range("i1_lower", i1_min, -4194304, 4194303);
    check_range("i2_upper", i2_max, -4194304, 4194303);
    check_range("i2_lower", i2_min, -4194304, 4194303);

    // Short asynchronous reset pulse between clock edges while running.
    @(negedge clk);
    #1;
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_pdm", pdm_out, 0);
    check("async_strobe", update_strobe, 0);
    check("async_active", active, 0);
    check("async_idle", idle, 1);
    check("async_gain", dut.gain, 0);
    #2;
    rst_n = 1'b1;
    #0.5;
    check("post_release_idle", idle, 1);
    check_release();
    check("post_release_gain", dut.gain, 0);
    check("post_release_active", active, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
